// File: rtl/usbkbd_event_sched.sv
// ============================================================================
// usbkbd_event_sched - services usbkbd report interrupts, diffs successive boot
// reports into key make/break events and queues them in a small FIFO.
// Optional typematic repeat: define USBKBD_TYPEMATIC_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module usbkbd_event_sched #(
    parameter int DEPTH        = 16,
    parameter int DELAY_CYCLES = 40000000,
    parameter int RATE_CYCLES  = 2666667
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic [63:0]              report,
    input  logic                     interrupt,
    output logic                     intack,
    output logic                     ev_valid,
    output logic [8:0]               ev_data,
    input  logic                     ev_ready,
    output logic [$clog2(DEPTH):0]   ev_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACK    = 3'd1;
    localparam logic [2:0] S_MODS   = 3'd2;
    localparam logic [2:0] S_REL    = 3'd3;
    localparam logic [2:0] S_PRESS  = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [63:0]   cur_q, cur_d;
    logic [63:0]   prev_q, prev_d;
    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;

    logic [7:0] cur_slot  [8];
    logic [7:0] prev_slot [8];
    logic [7:0] scan_code;
    logic       in_other, dup, rollover;
    logic       want, full, pop, space, scan_push, advance;
    logic [8:0] push_data;
    logic       fifo_push;
    logic [8:0] fifo_data;

    // Slots 6 and 7 read as zero so idx can address the arrays without range concerns.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            cur_slot[k]  = 8'h00;
            prev_slot[k] = 8'h00;
        end
        for (int k = 0; k < 6; k++) begin
            cur_slot[k]  = cur_q[16+8*k +: 8];
            prev_slot[k] = prev_q[16+8*k +: 8];
        end
    end

    always_comb begin
        scan_code = (state_q == S_PRESS) ? cur_slot[idx_q] : prev_slot[idx_q];
        in_other  = 1'b0;
        dup       = 1'b0;
        rollover  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            rollover = rollover | (cur_slot[k] == 8'h01);
            if (state_q == S_PRESS) begin
                in_other = in_other | (prev_slot[k] == scan_code);
                if (k < int'(idx_q)) dup = dup | (cur_slot[k] == scan_code);
            end else begin
                in_other = in_other | (cur_slot[k] == scan_code);
                if (k < int'(idx_q)) dup = dup | (prev_slot[k] == scan_code);
            end
        end
        want      = 1'b0;
        push_data = 9'h000;
        case (state_q)
            S_MODS: begin
                want      = cur_q[idx_q] != prev_q[idx_q];
                push_data = {cur_q[idx_q], 8'hE0 | {5'b00000, idx_q}};
            end
            S_REL, S_PRESS: begin
                want      = (scan_code >= 8'h04) && !in_other && !dup;
                push_data = {state_q == S_PRESS, scan_code};
            end
            default: ;
        endcase
    end

    // A pending push stalls the scan only while there is no room, even counting a same-cycle pop.
    assign full      = (cnt_q == FULL_CNT);
    assign pop       = (cnt_q != '0) && ev_ready;
    assign space     = !full || pop;
    assign scan_push = want && space;
    assign advance   = !want || space;

`ifdef USBKBD_TYPEMATIC_EN
    logic        rep_armed_q;
    logic [7:0]  rep_code_q;
    logic [31:0] rep_timer_q;
    logic        rep_push;

    assign rep_push  = rep_armed_q && (rep_timer_q == 32'd0) && (state_q == S_IDLE) && !full;
    assign fifo_push = scan_push || rep_push;
    assign fifo_data = rep_push ? {1'b1, rep_code_q} : push_data;

    // Loading N-1 makes the repeat land exactly N cycles after the push that armed it.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rep_armed_q <= 1'b0;
            rep_code_q  <= 8'h00;
            rep_timer_q <= 32'd0;
        end else if (state_q == S_ACK && rollover) begin
            rep_armed_q <= 1'b0;
        end else if (scan_push && state_q == S_PRESS) begin
            rep_armed_q <= 1'b1;
            rep_code_q  <= scan_code;
            rep_timer_q <= 32'(DELAY_CYCLES - 1);
        end else if (scan_push && state_q == S_REL && scan_code == rep_code_q) begin
            rep_armed_q <= 1'b0;
        end else if (rep_push) begin
            rep_timer_q <= 32'(RATE_CYCLES - 1);
        end else if (rep_armed_q && rep_timer_q != 32'd0) begin
            rep_timer_q <= rep_timer_q - 32'd1;
        end
    end
`else
    assign fifo_push = scan_push;
    assign fifo_data = push_data;
`endif

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cur_q   <= 64'd0;
            prev_q  <= 64'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 9'h000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            prev_q  <= prev_d;
            if (fifo_push) begin
                mem_q[wptr_q] <= fifo_data;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            case ({fifo_push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        prev_d  = prev_q;
        case (state_q)
            S_IDLE: begin
                if (interrupt) begin
                    cur_d   = report;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                idx_d   = 3'd0;
                state_d = rollover ? S_IDLE : S_MODS;
            end
            S_MODS: begin
                if (advance) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_REL;
                end
            end
            S_REL: begin
                if (advance) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd5) begin
                        idx_d   = 3'd0;
                        state_d = S_PRESS;
                    end
                end
            end
            S_PRESS: begin
                if (advance) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd5) begin
                        idx_d   = 3'd0;
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                prev_d  = cur_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        intack   = (state_q == S_ACK);
        ev_valid = (cnt_q != '0);
        ev_data  = mem_q[rptr_q];
        ev_count = cnt_q;
    end

endmodule

`default_nettype wire
